pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Sequences the two decode-side pipeline registers of the simple CPU. Generates hold, bubble and flush controls for each register.
- Detects load-use hazards between the instruction in decode and the load in execute.
- Kills wrong-path instructions after a taken PC load.
- Stalls on input instructions until external input data is valid.
- Sits beside the decode unit; its outputs drive register enables and control-zeroing muxes.

Parameters:
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7)
FLUSH_CYCLES, 2, cycles flush_OUT held after a taken PC load (1..7)
CNT_W, 16, width of stall performance counter

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  synchronous reset, active low
dec_valid_IN  input  1  decode stage holds a valid instruction
dec_srcA_IN  input  3  decode source register A
dec_srcB_IN  input  3  decode source register B
dec_useA_IN  input  1  srcA is read
dec_useB_IN  input  1  srcB is read
ex_wren_IN  input  1  execute-stage instruction writes register file
ex_writeAd_IN  input  3  execute-stage destination register
ex_isload_IN  input  1  execute-stage instruction is a memory load (MAD_MUX path)
ex_pcload_IN  input  1  execute-stage branch resolved taken
ex_input_IN  input  1  execute-stage instruction is an input op
in_valid_IN  input  1  external input data valid
hold_dec_OUT  output  1  freeze PC and stage-one register
hold_ex_OUT  output  1  freeze stage-two register
bubble_OUT  output  1  load NOP into stage-two register: wren, write, PC_load, SPR_w/i/d, SW forced to 0
flush_OUT  output  1  clear stage-one register valid
in_ack_OUT  output  1  input data consumed
state_OUT  output  2  current FSM state
stall_count_OUT  output  CNT_W  stall cycle counter

Behaviour:
- Reset is synchronous: when RST_N=0 at a rising edge, next state is RUN and the counter is cleared. All outputs are 0 while in RUN with no hazard.
- A reset asserted mid-stall or mid-flush aborts that operation. Outputs are valid one cycle after reset.
- States: RUN=0, LD_STALL=1, FLUSH=2, IN_WAIT=3.
- hazard = dec_valid_IN & ex_wren_IN & ex_isload_IN & ((dec_useA_IN & srcA==ex_writeAd_IN) | (dec_useB_IN & srcB==ex_writeAd_IN)). Register 0 is not special.
- Event priority in the same cycle: ex_pcload_IN > (ex_input_IN & !in_valid_IN) > hazard.
- Outputs are combinational (Mealy), so a stall takes effect in the detection cycle.
- RUN, ex_pcload_IN=1:
  - flush_OUT=1, bubble_OUT=1.
  - If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1.
- RUN, input pending:
  - hold_dec_OUT=1, hold_ex_OUT=1.
  - Go to IN_WAIT.
- RUN, hazard:
  - hold_dec_OUT=1, bubble_OUT=1.
  - If LOAD_STALL_CYCLES>1, go to LD_STALL with cnt=LOAD_STALL_CYCLES-1.
- RUN, ex_input_IN & in_valid_IN: in_ack_OUT=1 for that cycle; no stall.
- LD_STALL: hold_dec_OUT=1, bubble_OUT=1; cnt decrements; return to RUN on the cycle cnt==1.
- FLUSH:
  - flush_OUT=1, bubble_OUT=1; return to RUN when cnt==1.
  - Hazard and input are ignored in FLUSH.
  - A new ex_pcload_IN reloads cnt=FLUSH_CYCLES-1.
- IN_WAIT: hold_dec_OUT=1, hold_ex_OUT=1 until in_valid_IN=1. In that cycle: in_ack_OUT=1, holds deasserted, next state RUN.
- ex_pcload_IN in LD_STALL or IN_WAIT preempts it: flush behaviour as in RUN, next state FLUSH, or RUN if FLUSH_CYCLES==1.
- Control outputs never assert in the same cycle in a conflicting way: hold_ex_OUT and bubble_OUT are mutually exclusive.
- cnt is 3 bits wide.

Optional Feature:
- Macro: PIPE_STALL_COUNTER_EN.
- Defined: stall_count_OUT increments by 1 each cycle hold_dec_OUT=1. It saturates at all-ones and clears on reset.
- Undefined: stall_count_OUT is tied to 0 and no counter flops exist.

Test Plan:
- Load r3 in execute (ex_wren=1, ex_isload=1, ex_writeAd=3), decode reads srcA=3 with useA=1 -> hold_dec_OUT=1 and bubble_OUT=1 for exactly 1 cycle (default), then state_OUT=0.
- Same as above but useA=0, or ex_isload=0 -> no hold, no bubble.
- ex_pcload_IN=1 for 1 cycle -> flush_OUT=1 for 2 cycles; state_OUT goes 0 -> 2 -> 0. A hazard during the second cycle is ignored.
- ex_input_IN=1, in_valid_IN=0 for 4 cycles, then 1 -> hold_dec_OUT=hold_ex_OUT=1 for 4 cycles, then in_ack_OUT=1 for 1 cycle.
- ex_pcload_IN, hazard and pending input all in one cycle -> only flush_OUT and bubble_OUT assert; next state FLUSH.
- RST_N=0 during IN_WAIT -> state_OUT=0 and all outputs 0 after the edge. With PIPE_STALL_COUNTER_EN defined, stall_count_OUT=0 after reset and equals 5 after the load-use plus input scenarios.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Decode-side hazard sequencer: load-use stalls, taken-branch flushes and input-wait holds.
// Optional stall-cycle performance counter enabled by defining PIPE_STALL_COUNTER_EN.
module pipeline_hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 2,
    parameter int CNT_W             = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             dec_valid_IN,
    input  logic [2:0]       dec_srcA_IN,
    input  logic [2:0]       dec_srcB_IN,
    input  logic             dec_useA_IN,
    input  logic             dec_useB_IN,
    input  logic             ex_wren_IN,
    input  logic [2:0]       ex_writeAd_IN,
    input  logic             ex_isload_IN,
    input  logic             ex_pcload_IN,
    input  logic             ex_input_IN,
    input  logic             in_valid_IN,
    output logic             hold_dec_OUT,
    output logic             hold_ex_OUT,
    output logic             bubble_OUT,
    output logic             flush_OUT,
    output logic             in_ack_OUT,
    output logic [1:0]       state_OUT,
    output logic [CNT_W-1:0] stall_count_OUT
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        FLUSH    = 2'd2,
        IN_WAIT  = 2'd3
    } state_t;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

    state_t     state_reg, state_next;
    logic [2:0] cnt_reg, cnt_next;

    logic [1:0][2:0] src_sel;
    logic [1:0]      use_sel;
    logic [1:0]      src_match;
    logic            hazard;
    logic            input_pending;

    assign src_sel = {dec_srcB_IN, dec_srcA_IN};
    assign use_sel = {dec_useB_IN, dec_useA_IN};

    // Register 0 is an ordinary register here, so no zero-index exclusion.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src_cmp
            assign src_match[gi] = use_sel[gi] & (src_sel[gi] == ex_writeAd_IN);
        end
    endgenerate

    assign hazard        = dec_valid_IN & ex_wren_IN & ex_isload_IN & (|src_match);
    assign input_pending = ex_input_IN & ~in_valid_IN;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg <= RUN;
            cnt_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        hold_dec_OUT = 1'b0;
        hold_ex_OUT  = 1'b0;
        bubble_OUT   = 1'b0;
        flush_OUT    = 1'b0;
        in_ack_OUT   = 1'b0;

        // A taken branch wins in every state; inside FLUSH it simply restarts the window.
        if (ex_pcload_IN) begin
            flush_OUT  = 1'b1;
            bubble_OUT = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_next = FLUSH;
                cnt_next   = FLUSH_RELOAD;
            end else begin
                state_next = RUN;
            end
        end else begin
            case (state_reg)
                RUN: begin
                    if (input_pending) begin
                        hold_dec_OUT = 1'b1;
                        hold_ex_OUT  = 1'b1;
                        state_next   = IN_WAIT;
                    end else begin
                        if (hazard) begin
                            hold_dec_OUT = 1'b1;
                            bubble_OUT   = 1'b1;
                            if (LOAD_STALL_CYCLES > 1) begin
                                state_next = LD_STALL;
                                cnt_next   = STALL_RELOAD;
                            end
                        end
                        // Execute is never held on this path, so the input op retires now.
                        in_ack_OUT = ex_input_IN & in_valid_IN;
                    end
                end
                LD_STALL: begin
                    hold_dec_OUT = 1'b1;
                    bubble_OUT   = 1'b1;
                    if (cnt_reg <= 3'd1) begin
                        state_next = RUN;
                    end else begin
                        cnt_next = cnt_reg - 3'd1;
                    end
                end
                FLUSH: begin
                    flush_OUT  = 1'b1;
                    bubble_OUT = 1'b1;
                    if (cnt_reg <= 3'd1) begin
                        state_next = RUN;
                    end else begin
                        cnt_next = cnt_reg - 3'd1;
                    end
                end
                IN_WAIT: begin
                    if (in_valid_IN) begin
                        in_ack_OUT = 1'b1;
                        state_next = RUN;
                    end else begin
                        hold_dec_OUT = 1'b1;
                        hold_ex_OUT  = 1'b1;
                    end
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    assign state_OUT = state_reg;

`ifdef PIPE_STALL_COUNTER_EN
    logic [CNT_W-1:0] stall_count_reg;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            stall_count_reg <= '0;
        end else if (hold_dec_OUT && (stall_count_reg != '1)) begin
            stall_count_reg <= stall_count_reg + 1'b1;
        end
    end

    assign stall_count_OUT = stall_count_reg;
`else
    assign stall_count_OUT = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios then randomized traffic
// against a remaining-cycles reference model.
module tb_pipeline_hazard_ctrl;

    localparam int LSC   = 1;
    localparam int FC    = 2;
    localparam int CNT_W = 16;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             dec_valid_IN, dec_useA_IN, dec_useB_IN;
    logic [2:0]       dec_srcA_IN, dec_srcB_IN, ex_writeAd_IN;
    logic             ex_wren_IN, ex_isload_IN, ex_pcload_IN, ex_input_IN, in_valid_IN;
    logic             hold_dec_OUT, hold_ex_OUT, bubble_OUT, flush_OUT, in_ack_OUT;
    logic [1:0]       state_OUT;
    logic [CNT_W-1:0] stall_count_OUT;

    int tests_run = 0;
    int failures  = 0;
    int cyc       = 0;

    // Reference model: how many more cycles each activity still owns.
    int flush_left = 0, stall_left = 0;
    bit waiting = 1'b0;
    int n_flush, n_stall;
    bit n_wait;
    int exp_cnt = 0;
    bit e_hd, e_he, e_bub, e_fl, e_ack;
    int e_state;

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl #(
        .LOAD_STALL_CYCLES(LSC),
        .FLUSH_CYCLES     (FC),
        .CNT_W            (CNT_W)
    ) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .dec_valid_IN   (dec_valid_IN),
        .dec_srcA_IN    (dec_srcA_IN),
        .dec_srcB_IN    (dec_srcB_IN),
        .dec_useA_IN    (dec_useA_IN),
        .dec_useB_IN    (dec_useB_IN),
        .ex_wren_IN     (ex_wren_IN),
        .ex_writeAd_IN  (ex_writeAd_IN),
        .ex_isload_IN   (ex_isload_IN),
        .ex_pcload_IN   (ex_pcload_IN),
        .ex_input_IN    (ex_input_IN),
        .in_valid_IN    (in_valid_IN),
        .hold_dec_OUT   (hold_dec_OUT),
        .hold_ex_OUT    (hold_ex_OUT),
        .bubble_OUT     (bubble_OUT),
        .flush_OUT      (flush_OUT),
        .in_ack_OUT     (in_ack_OUT),
        .state_OUT      (state_OUT),
        .stall_count_OUT(stall_count_OUT)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s cyc=%0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic idle_inputs();
        dec_valid_IN = 0; dec_srcA_IN = 0; dec_srcB_IN = 0; dec_useA_IN = 0; dec_useB_IN = 0;
        ex_wren_IN = 0; ex_writeAd_IN = 0; ex_isload_IN = 0; ex_pcload_IN = 0;
        ex_input_IN = 0; in_valid_IN = 0;
    endtask

    task automatic set_load_use(input bit use_a, input bit is_load);
        dec_valid_IN = 1; dec_srcA_IN = 3'd3; dec_useA_IN = use_a;
        dec_srcB_IN = 3'd5; dec_useB_IN = 1;
        ex_wren_IN = 1; ex_isload_IN = is_load; ex_writeAd_IN = 3'd3;
    endtask

    function automatic bit hazard_now();
        bit a_hit = dec_useA_IN && (dec_srcA_IN == ex_writeAd_IN);
        bit b_hit = dec_useB_IN && (dec_srcB_IN == ex_writeAd_IN);
        return dec_valid_IN && ex_wren_IN && ex_isload_IN && (a_hit || b_hit);
    endfunction

    // Expected outputs for the current cycle and the model's next remaining-cycle counts.
    task automatic predict();
        {e_hd, e_he, e_bub, e_fl, e_ack} = '0;
        n_flush = flush_left; n_stall = stall_left; n_wait = waiting;
        e_state = (flush_left > 0) ? 2 : waiting ? 3 : (stall_left > 0) ? 1 : 0;
        if (ex_pcload_IN) begin
            e_fl = 1; e_bub = 1;
            n_flush = FC - 1; n_stall = 0; n_wait = 0;
        end else if (flush_left > 0) begin
            e_fl = 1; e_bub = 1;
            n_flush = flush_left - 1;
        end else if (waiting) begin
            if (in_valid_IN) begin
                e_ack = 1; n_wait = 0;
            end else begin
                e_hd = 1; e_he = 1;
            end
        end else if (stall_left > 0) begin
            e_hd = 1; e_bub = 1;
            n_stall = stall_left - 1;
        end else if (ex_input_IN && !in_valid_IN) begin
            e_hd = 1; e_he = 1; n_wait = 1;
        end else begin
            if (hazard_now()) begin
                e_hd = 1; e_bub = 1; n_stall = LSC - 1;
            end
            e_ack = ex_input_IN && in_valid_IN;
        end
    endtask

    task automatic run_cycle();
        predict();
        @(negedge CLK);
        check("state", 32'(state_OUT), 32'(e_state));
        check("hold_dec", 32'(hold_dec_OUT), 32'(e_hd));
        check("hold_ex", 32'(hold_ex_OUT), 32'(e_he));
        check("bubble", 32'(bubble_OUT), 32'(e_bub));
        check("flush", 32'(flush_OUT), 32'(e_fl));
        check("in_ack", 32'(in_ack_OUT), 32'(e_ack));
        check("hold_ex_bubble_excl", 32'(hold_ex_OUT & bubble_OUT), 32'd0);
        check("stall_count", 32'(stall_count_OUT), 32'(exp_cnt));
        $display("[TB] cyc=%0d rst_n=%0b pcl=%0b inp=%0b iv=%0b haz=%0b -> st=%0d hd=%0b he=%0b bub=%0b fl=%0b ack=%0b cnt=%0d",
                 cyc, RST_N, ex_pcload_IN, ex_input_IN, in_valid_IN, hazard_now(), state_OUT,
                 hold_dec_OUT, hold_ex_OUT, bubble_OUT, flush_OUT, in_ack_OUT, stall_count_OUT);
        @(posedge CLK);
        if (!RST_N) begin
            flush_left = 0; stall_left = 0; waiting = 0; exp_cnt = 0;
        end else begin
`ifdef PIPE_STALL_COUNTER_EN
            if (e_hd && exp_cnt < (2 ** CNT_W) - 1) exp_cnt++;
`endif
            flush_left = n_flush; stall_left = n_stall; waiting = n_wait;
        end
        cyc++;
        #1;
    endtask

    initial begin
        idle_inputs();
        RST_N = 0;
        #1;
        // Reset: model starts from an unknown-but-reset DUT after two reset edges.
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST_N = 1;
        run_cycle();

        // Load-use hazard, then idle.
        set_load_use(1, 1); run_cycle();
        idle_inputs(); run_cycle(); run_cycle();

        // Input stall: four cycles pending, then data arrives.
        ex_input_IN = 1; in_valid_IN = 0;
        repeat (4) run_cycle();
        in_valid_IN = 1; run_cycle();
        idle_inputs(); run_cycle();
`ifdef PIPE_STALL_COUNTER_EN
        check("stall_count_after_scenarios", 32'(stall_count_OUT), 32'd5);
`endif

        // No hazard when source unused or execute op is not a load.
        set_load_use(0, 1); dec_useB_IN = 0; run_cycle();
        set_load_use(1, 0); run_cycle();
        idle_inputs(); run_cycle();

        // Taken branch, hazard in the second flush cycle must be ignored.
        ex_pcload_IN = 1; run_cycle();
        idle_inputs(); set_load_use(1, 1); run_cycle();
        idle_inputs(); run_cycle();

        // All three events together: flush wins.
        set_load_use(1, 1); ex_pcload_IN = 1; ex_input_IN = 1; in_valid_IN = 0; run_cycle();
        idle_inputs(); run_cycle(); run_cycle();

        // Reset in the middle of an input wait.
        ex_input_IN = 1; run_cycle(); run_cycle();
        RST_N = 0; run_cycle();
        RST_N = 1; idle_inputs(); run_cycle();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            dec_valid_IN  = ($urandom_range(0, 3) != 0);
            dec_srcA_IN   = 3'($urandom_range(0, 3));
            dec_srcB_IN   = 3'($urandom_range(0, 3));
            dec_useA_IN   = 1'($urandom_range(0, 1));
            dec_useB_IN   = 1'($urandom_range(0, 1));
            ex_wren_IN    = ($urandom_range(0, 3) != 0);
            ex_writeAd_IN = 3'($urandom_range(0, 3));
            ex_isload_IN  = 1'($urandom_range(0, 1));
            ex_pcload_IN  = ($urandom_range(0, 7) == 0);
            ex_input_IN   = ($urandom_range(0, 5) == 0);
            in_valid_IN   = 1'($urandom_range(0, 1));
            RST_N         = ($urandom_range(0, 63) != 0);
            run_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
